// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies, decode helpers.
// Optional MDU_MADD_EN adds the madd/maddu/msub/msubu accumulate ops.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Any op that reads or writes HI/LO; decode uses this for its dependence stall.
  function automatic logic is_md_op(input md_op_e op);
    return (op != MD_NONE) && (op <= MD_MSUBU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_arith(input md_op_e op);
`ifdef MDU_MADD_EN
    return ((op >= MD_MULT) && (op <= MD_DIVU)) || ((op >= MD_MADD) && (op <= MD_MSUBU));
`else
    return (op >= MD_MULT) && (op <= MD_DIVU);
`endif
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {hi,lo} result for the arithmetic md ops.
// Divide by zero (and non-arithmetic ops) return the current {hi,lo} unchanged.
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] q_s, r_s, q_u, r_u;
  logic               b_zero, s_ovf;

  assign prod_s = $signed(a) * $signed(b);
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign b_zero = (b == 32'd0);
  // INT_MIN / -1 overflows; pin it to a defined result instead of leaving it to the tool.
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    q_s = 32'd0;
    r_s = 32'd0;
    q_u = 32'd0;
    r_u = 32'd0;
    if (!b_zero) begin
      q_u = a / b;
      r_u = a % b;
      if (s_ovf) begin
        q_s = a;
        r_s = 32'd0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    res = {hi, lo};
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   if (!b_zero) res = {r_s, q_s};
      MD_DIVU:  if (!b_zero) res = {r_u, q_u};
`ifdef MDU_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
      MD_MSUB:  res = {hi, lo} - prod_s;
      MD_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency busy window, owns HI/LO, serves mf/mt.
// Build with MDU_MADD_EN to enable the multiply-accumulate ops.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] hi_nx, lo_nx;
  logic [63:0] res;

  md_calc u_calc (
    .op  (md_op),
    .a   (A),
    .b   (B),
    .hi  (hi),
    .lo  (lo),
    .res (res)
  );

  // Result is computed and buffered at the start edge; HI/LO commit when cnt hits 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      hi_nx <= '0;
      lo_nx <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && is_arith(md_op)) begin
            hi_nx <= res[63:32];
            lo_nx <= res[31:0];
            cnt   <= is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= MD_RUN;
          end else if (md_op == MD_MTHI) begin
            hi <= A;
          end else if (md_op == MD_MTLO) begin
            lo <= A;
          end
        end
        MD_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= hi_nx;
            lo    <= lo_nx;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi;
      MD_MFLO: md_out = lo;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed expectations.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  md_op_e      op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (op),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then check busy over n cycles and hold of old HI/LO.
  task automatic launch(input md_op_e o, input logic [31:0] x, input logic [31:0] y,
                        input int n, input logic [31:0] old_hi, input logic [31:0] old_lo);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; op = MD_NONE;
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("busy_t+%0d", i), {31'd0, busy}, 32'd1);
      if (i < n) tick();
    end
    chk("hi_held", hi, old_hi);
    chk("lo_held", lo, old_lo);
    tick();
    chk("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = MD_NONE; a = '0; b = '0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mdout", md_out, 32'd0);

    // mult -1 * 2, then multu of the same bit patterns
    launch(MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'd0, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // signed div truncates toward zero, remainder follows dividend
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'h1, 32'hFFFF_FFFE);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divide by zero: full busy window, HI/LO untouched
    launch(MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("div0_lo", lo, 32'hFFFF_FFFD);
    chk("div0_hi", hi, 32'hFFFF_FFFF);

    launch(MD_DIVU, 32'd100, 32'd7, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // mthi/mtlo without start, then mf reads
    op = MD_MTHI; a = 32'h1234;
    tick();
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = MD_MFHI; #1;
    chk("mfhi_out", md_out, 32'h1234);
    op = MD_MFLO; #1;
    chk("mflo_out", md_out, 32'd14);
    tick();
    chk("mf_nochg_hi", hi, 32'h1234);
    op = MD_MTLO; a = 32'h55;
    tick();
    chk("mtlo_lo", lo, 32'h55);
    op = MD_NONE; #1;
    chk("none_out", md_out, 32'd0);

    // start / mthi during RUN must be ignored; original result lands on schedule
    op = MD_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0; op = MD_NONE;
    tick(); tick();
    op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = MD_MTHI; a = 32'hDEAD;
    tick();
    op = MD_NONE;
    chk("run_busy5", {31'd0, busy}, 32'd1);
    chk("run_hi_held", hi, 32'h1234);
    tick();
    chk("run_busy_done", {31'd0, busy}, 32'd0);
    chk("run_lo", lo, 32'd15);
    chk("run_hi", hi, 32'd0);

    // start with non-arithmetic ops
    op = MD_NONE; start = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    chk("none_start_busy", {31'd0, busy}, 32'd0);
    op = MD_MFHI;
    tick();
    start = 1'b0;
    chk("mf_start_busy", {31'd0, busy}, 32'd0);
    chk("mf_start_lo", lo, 32'd15);

`ifdef MDU_MADD_EN
    op = MD_MTHI; a = 32'd0; tick();
    op = MD_MTLO; a = 32'd10; tick();
    launch(MD_MADD, 32'd3, 32'd4, 5, 32'd0, 32'd10);
    chk("madd_lo", lo, 32'd22);
    chk("madd_hi", hi, 32'd0);
    op = MD_MTLO; a = 32'd0; tick();
    launch(MD_MSUBU, 32'd1, 32'd1, 5, 32'd0, 32'd0);
    chk("msubu_hi", hi, 32'hFFFF_FFFF);
    chk("msubu_lo", lo, 32'hFFFF_FFFF);
`else
    op = MD_MADD; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0; op = MD_NONE;
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    chk("madd_off_lo", lo, 32'd15);
    chk("madd_off_hi", hi, 32'd0);
`endif

    // reset held two cycles mid-div discards the pending result
    op = MD_MTHI; a = 32'hAAAA; tick();
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = MD_NONE;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("rstmid_late_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_late_lo", lo, 32'd0);

    // reset on the completion edge wins over the write
    op = MD_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = MD_NONE;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rstedge_lo", lo, 32'd0);
    chk("rstedge_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rstedge_lo2", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
